// File: rtl/delivery_display_scan_if.sv
// delivery_display_scan_if: map/lane inputs and row/column drive outputs of the LED scanner
interface delivery_display_scan_if #(parameter int ROWS = 16);
  logic                    enable;
  logic [4*ROWS-1:0]       map_obstacle;
  logic [4*ROWS-1:0]       map_objective;
  logic [3:0]              player_position;
  logic                    game_over;
  logic [$clog2(ROWS)-1:0] row_sel;
  logic                    row_en;
  logic [3:0]              col_obstacle;
  logic [3:0]              col_objective;
  logic [3:0]              col_player;
  logic                    frame_start;
  modport master (
    output enable, map_obstacle, map_objective, player_position, game_over,
    input  row_sel, row_en, col_obstacle, col_objective, col_player, frame_start
  );
  modport slave (
    input  enable, map_obstacle, map_objective, player_position, game_over,
    output row_sel, row_en, col_obstacle, col_objective, col_player, frame_start
  );
endinterface

// File: rtl/delivery_display_scan.sv
// delivery_display_scan: frame-coherent row scanner for a 4-column LED matrix with game-over player blink.
// Optional DELIVERY_SCAN_BLANK_EN inserts a one-cycle blank after every row.
module delivery_display_scan #(
  parameter int ROWS         = 16,
  parameter int DWELL        = 1,
  parameter int BLINK_FRAMES = 8
) (
  input logic clock,
  input logic reset,
  delivery_display_scan_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;
  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [FW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              blink_q, blink_d;
  logic [4*ROWS-1:0] obs_q, obs_d, objv_q, objv_d;
  logic [3:0]        ply_q, ply_d;
  logic              go_q, go_d;
  logic [RW-1:0]     row_sel_q, row_sel_d;
  logic              row_en_q, row_en_d;
  logic [3:0]        col_obs_q, col_obs_d, col_objv_q, col_objv_d, col_ply_q, col_ply_d;
  logic              frame_start_q, frame_start_d;
  logic              last_dwell, last_row, cnt_wrap, show;
  assign last_dwell = dwell_q == DW'(DWELL - 1);
  assign last_row   = row_q == RW'(ROWS - 1);
  assign cnt_inc    = cnt_q + 1'b1;
  assign cnt_wrap   = cnt_inc == FW'(BLINK_FRAMES);
  // Outputs are registered from the next-state values so they line up with state_q.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    obs_d   = obs_q;
    objv_d  = objv_q;
    ply_d   = ply_q;
    go_d    = go_q;
    case (state_q)
      IDLE: state_d = bus.enable ? LOAD : IDLE;
      LOAD: begin
        obs_d   = bus.map_obstacle;
        objv_d  = bus.map_objective;
        ply_d   = bus.player_position;
        go_d    = bus.game_over;
        cnt_d   = cnt_wrap ? '0 : cnt_inc;
        blink_d = blink_q ^ cnt_wrap;
        state_d = SHOW;
        row_d   = '0;
        dwell_d = '0;
      end
      SHOW: begin
        dwell_d = last_dwell ? '0 : dwell_q + 1'b1;
`ifdef DELIVERY_SCAN_BLANK_EN
        state_d = last_dwell ? BLANK : SHOW;
`else
        state_d = !last_dwell ? SHOW : last_row ? (bus.enable ? LOAD : IDLE) : SHOW;
        row_d   = (last_dwell && !last_row) ? row_q + 1'b1 : row_q;
`endif
      end
      default: begin
        state_d = last_row ? (bus.enable ? LOAD : IDLE) : SHOW;
        row_d   = last_row ? row_q : row_q + 1'b1;
      end
    endcase
    show          = state_d == SHOW;
    row_sel_d     = (show || state_d == BLANK) ? row_d : '0;
    row_en_d      = show;
    col_obs_d     = show ? obs_d[{row_d, 2'b00} +: 4] : 4'h0;
    col_objv_d    = show ? objv_d[{row_d, 2'b00} +: 4] : 4'h0;
    col_ply_d     = (show && row_d == '0 && !(go_d && blink_d)) ? ply_d : 4'h0;
    frame_start_d = state_d == LOAD;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      dwell_q       <= '0;
      cnt_q         <= '0;
      blink_q       <= 1'b0;
      obs_q         <= '0;
      objv_q        <= '0;
      ply_q         <= '0;
      go_q          <= 1'b0;
      row_sel_q     <= '0;
      row_en_q      <= 1'b0;
      col_obs_q     <= '0;
      col_objv_q    <= '0;
      col_ply_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      cnt_q         <= cnt_d;
      blink_q       <= blink_d;
      obs_q         <= obs_d;
      objv_q        <= objv_d;
      ply_q         <= ply_d;
      go_q          <= go_d;
      row_sel_q     <= row_sel_d;
      row_en_q      <= row_en_d;
      col_obs_q     <= col_obs_d;
      col_objv_q    <= col_objv_d;
      col_ply_q     <= col_ply_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign bus.row_sel       = row_sel_q;
  assign bus.row_en        = row_en_q;
  assign bus.col_obstacle  = col_obs_q;
  assign bus.col_objective = col_objv_q;
  assign bus.col_player    = col_ply_q;
  assign bus.frame_start   = frame_start_q;
endmodule
